arb_burst_lock: RTL and testbench
=================================

Name: arb_burst_lock

Overview:
- Sits between N burst requestors and the shared round-robin arbiter on the axi2ahb request path.
- Presents requests to the arbiter and latches the one-hot winner.
- Holds the connection for the whole burst: keeps the arbiter pointed at the owner and forwards the owner's beat stream to a single downstream port.
- Drives the arbiter's priority-update on the final beat, so priority advances only at burst boundaries.

Parameters:
- N, 4, number of requestors (≥2); S = $clog2(N).
- DW, 32, beat data width.
- LW, 8, burst length field width; len encodes beats-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  N  per-requestor beat valid; also the request for arbitration.
- in_len  in  N*LW  per-requestor burst length (beats-1); slice i = [i*LW +: LW]; sampled only at lock.
- in_data  in  N*DW  per-requestor beat data; slice i = [i*DW +: DW].
- in_ready  out  N  per-requestor beat ready.
- out_valid  out  1  forwarded beat valid.
- out_data  out  DW  forwarded beat data.
- out_src  out  S  index of the current owner.
- out_first  out  1  current beat is the first of its burst.
- out_last  out  1  current beat is the last of its burst.
- out_ready  in  1  downstream ready.
- arb_request  out  N  request vector to the arbiter.
- arb_grant  in  N  one-hot grant from the arbiter.
- arb_anygnt  in  1  arbiter any-grant.
- arb_update_pri  out  1  arbiter priority-advance strobe.
- err_grant  out  1  sticky protocol error flag.

Behaviour:
- FSM states: IDLE, LOCKED. Registers: state, owner (S bits), cnt (LW bits), first_f, err_grant.
- Reset: state=IDLE, owner=0, cnt=0, first_f=0, err_grant=0. Consequences:
  - in_ready=0, out_valid=0, out_first=0, out_last=0, arb_update_pri=0, out_src=0, out_data=in_data slice 0.
  - arb_request=in_valid (IDLE rule).
- IDLE:
  - arb_request=in_valid; arb_update_pri=0; in_ready=0; out_valid=0. No beats are forwarded in IDLE.
  - If arb_anygnt=1: owner<=encode(arb_grant), cnt<=in_len[owner slice], first_f<=1, state<=LOCKED.
  - The arbiter then sets its priority to the winner (update_pri=0).
  - If arb_grant is not one-hot while arb_anygnt=1: err_grant<=1, and the lowest set bit is taken.
- LOCKED:
  - arb_request=onehot(owner), held regardless of in_valid, so the arbiter stays valid and keeps priority on the owner.
  - out_valid=in_valid[owner]; out_data=in_data[owner slice]; in_ready=onehot(owner) & {N{out_ready}}.
  - out_src=owner; out_first=first_f; out_last=(cnt==0).
  - Beat handshake hs=out_valid&out_ready:
    - hs && cnt!=0: cnt<=cnt-1; first_f<=0.
    - hs && cnt==0: arb_update_pri=1 (combinational, same cycle), state<=IDLE, first_f<=0.
  - The arbiter moves priority to owner+1 (wraps N-1→0) for the next arbitration.
  - arb_update_pri=0 in every other cycle.
  - If arb_grant != onehot(owner) in any LOCKED cycle: err_grant<=1 (sticky until rst); forwarding is unaffected.
- Latency and throughput:
  - 1 cycle from in_valid rising in IDLE to out_valid (lock cycle).
  - After the burst, 1 mandatory IDLE arbitration cycle.
  - Burst of L+1 beats with no stalls occupies L+2 cycles.
- Boundary conditions:
  - len=0: single beat; out_first=out_last=1 on the same beat.
  - len=2^LW-1: 2^LW beats; cnt counts down without wrap.
  - Owner drops in_valid mid-burst: out_valid=0, cnt/first_f hold, lock kept. Other requestors see in_ready=0 for the whole burst.
  - in_len changes after lock: ignored.
  - IDLE with in_valid=0: arb_anygnt=0, stay IDLE.
  - rst asserted mid-burst: immediate return to reset values. The partial burst is dropped; no update_pri is issued.

Test Plan:
- N=4, arbiter reset priority 0, all in_valid=1, all len=1, out_ready=1 → bursts granted in order src 0,1,2,3,0. Each burst is 2 beats with first/last on beats 1/2; arb_update_pri pulses once per burst on the last beat; 3 cycles per burst.
- Only req 2 valid, len=0 → lock at cycle 1; cycle 2 beat with out_first=out_last=1, out_src=2, update_pri=1; cycle 3 IDLE.
- Req 1 len=3, out_ready toggling 1,0,1,0… with req 0/3 also valid → exactly 4 beats from src 1, in order. in_ready[0]=in_ready[3]=0 throughout; cnt holds on stall cycles.
- Req 0 drops in_valid for 5 cycles mid-burst while req 3 is valid → no grant switch; arb_request stays 0001; burst resumes and completes before req 3 is served.
- len=255 on req 3 → exactly 256 beats, out_last only on beat 256, then return to IDLE.
- rst pulsed during beat 2 of a len=3 burst → outputs drop to reset values asynchronously. Next arbitration starts from IDLE with no update_pri pulse emitted. Forcing a mismatching arb_grant in LOCKED sets err_grant=1, which persists until rst.

Source files
------------

// File: rtl/arb_burst_lock.sv
// arb_burst_lock
//   Burst lock between N requestors and a shared round-robin arbiter.
//   In IDLE the raw beat valids are offered to the arbiter as requests and
//   the one-hot winner is latched. In LOCKED the arbiter is held on the
//   owner and the owner's beat stream is forwarded to one downstream port
//   until the last beat. On that beat the arbiter's priority-update is
//   pulsed, so priority only advances at burst boundaries.
//
//   Handshake: a beat transfers on a cycle where out_valid && out_ready.
//   out_valid never depends on out_ready. in_ready[i] is only high for the
//   owner while LOCKED, and it mirrors out_ready.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   in_valid[N]     per-requestor beat valid (also the arbitration request)
//   in_len[N*LW]    per-requestor burst length minus one, sampled at lock
//   in_data[N*DW]   per-requestor beat data
//   in_ready[N]     per-requestor beat ready
//   out_valid/out_data/out_src/out_first/out_last/out_ready  forwarded beat
//   arb_request[N]  request vector to the arbiter
//   arb_grant[N]    one-hot grant from the arbiter
//   arb_anygnt      arbiter any-grant
//   arb_update_pri  arbiter priority-advance strobe
//   err_grant       sticky grant protocol error
//   state_dbg       current FSM state (0 = IDLE, 1 = LOCKED)
module arb_burst_lock #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int LW = 8,
    localparam int S = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_valid,
    input  logic [N*LW-1:0] in_len,
    input  logic [N*DW-1:0] in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [S-1:0]    out_src,
    output logic            out_first,
    output logic            out_last,
    input  logic            out_ready,
    output logic [N-1:0]    arb_request,
    input  logic [N-1:0]    arb_grant,
    input  logic            arb_anygnt,
    output logic            arb_update_pri,
    output logic            err_grant,
    output logic            state_dbg
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    state_t          state;
    logic [S-1:0]    owner;
    logic [LW-1:0]   cnt;
    logic            first_f;

    logic [N-1:0]    owner_oh;
    logic [S-1:0]    grant_idx;
    logic            grant_onehot;
    logic            owner_valid;
    logic            hs;

    assign owner_oh     = ONE_N << owner;
    assign owner_valid  = in_valid[owner];
    assign hs           = (state == LOCKED) && owner_valid && out_ready;
    assign grant_onehot = (arb_grant != '0) && ((arb_grant & (arb_grant - ONE_N)) == '0);
    assign state_dbg    = state;

    // Lowest set bit wins, so a malformed multi-bit grant still picks a
    // deterministic owner while err_grant records the violation.
    always_comb begin
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (arb_grant[i]) grant_idx = S'(i);
        end
    end

    always_comb begin
        arb_request    = in_valid;
        in_ready       = '0;
        out_valid      = 1'b0;
        out_first      = 1'b0;
        out_last       = 1'b0;
        arb_update_pri = 1'b0;
        out_src        = owner;
        out_data       = in_data[int'(owner)*DW +: DW];
        if (state == LOCKED) begin
            // Keep the arbiter requesting the owner even while it idles,
            // otherwise it could re-arbitrate mid-burst.
            arb_request    = owner_oh;
            in_ready       = owner_oh & {N{out_ready}};
            out_valid      = owner_valid;
            out_first      = first_f;
            out_last       = (cnt == '0);
            arb_update_pri = hs && (cnt == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            cnt       <= '0;
            first_f   <= 1'b0;
            err_grant <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_anygnt) begin
                        owner   <= grant_idx;
                        cnt     <= in_len[int'(grant_idx)*LW +: LW];
                        first_f <= 1'b1;
                        state   <= LOCKED;
                        if (!grant_onehot) err_grant <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (arb_grant != owner_oh) err_grant <= 1'b1;
                    if (hs) begin
                        first_f <= 1'b0;
                        if (cnt == '0) state <= IDLE;
                        else           cnt   <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arb_burst_lock.sv
// Testbench for arb_burst_lock with a round-robin arbiter model.
module tb_arb_burst_lock;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int LW = 8;

    logic            clk;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N*LW-1:0] in_len;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;
    logic            out_first;
    logic            out_last;
    logic            out_ready;
    logic [N-1:0]    arb_request;
    logic [N-1:0]    arb_grant;
    logic            arb_anygnt;
    logic            arb_update_pri;
    logic            err_grant;
    logic            state_dbg;

    int checks   = 0;
    int failures = 0;
    int cur_row  = -1;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    arb_burst_lock #(.N(N), .DW(DW), .LW(LW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_len(in_len), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_first(out_first), .out_last(out_last), .out_ready(out_ready),
        .arb_request(arb_request), .arb_grant(arb_grant), .arb_anygnt(arb_anygnt),
        .arb_update_pri(arb_update_pri), .err_grant(err_grant), .state_dbg(state_dbg)
    );

    // ---------------- round-robin arbiter model ----------------
    logic [1:0]   ptr;
    logic [N-1:0] rr_grant;
    logic         force_en;
    logic [N-1:0] force_grant;
    logic         force_any;

    always_comb begin
        rr_grant = '0;
        for (int i = 0; i < N; i++) begin
            if (arb_request[(int'(ptr) + i) % N] && rr_grant == '0)
                rr_grant[(int'(ptr) + i) % N] = 1'b1;
        end
        arb_grant  = force_en ? force_grant : rr_grant;
        arb_anygnt = force_en ? force_any   : (arb_request != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= 2'd0;
        else if (arb_update_pri) ptr <= 2'((int'(out_src) + 1) % N);
    end

    // ---------------- helpers ----------------
    function automatic logic [DW-1:0] data_of(input int i);
        return 32'hD000_0000 + 32'(i) * 32'h0000_0111;
    endfunction

    function automatic logic [N*LW-1:0] mk_len(input int l0, l1, l2, l3);
        return {LW'(l3), LW'(l2), LW'(l1), LW'(l0)};
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%0h required=%0h", nm, cur_row, act, exp);
        end
    endtask

    // Leaves the bench at a falling edge with rst released.
    task automatic do_reset();
        @(negedge clk);
        force_en  = 1'b0;
        in_valid  = 4'b0110;
        out_ready = 1'b1;
        rst       = 1'b1;
        #1;
        cur_row = -1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_first", out_first, 0);
        chk("rst_last", out_last, 0);
        chk("rst_upd", arb_update_pri, 0);
        chk("rst_src", out_src, 0);
        chk("rst_data", out_data, data_of(0));
        chk("rst_req", arb_request, 4'b0110);
        chk("rst_err", err_grant, 0);
        chk("rst_state", state_dbg, 0);
        in_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic            rst_before;
        logic [N-1:0]    valid;
        logic [N*LW-1:0] len;
        logic            rdy;
        logic [N-1:0]    exp_req;
        logic [N-1:0]    exp_ready;
        logic            exp_valid;
        logic [1:0]      exp_src;
        logic            exp_first;
        logic            exp_last;
        logic            exp_upd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rb, input logic [N-1:0] v, input logic [N*LW-1:0] l,
                       input logic r, input logic [N-1:0] rq, input logic [N-1:0] ry,
                       input logic ov, input int src, input logic f, input logic la,
                       input logic up);
        vec_t e;
        e.rst_before = rb; e.valid = v; e.len = l; e.rdy = r;
        e.exp_req = rq; e.exp_ready = ry; e.exp_valid = ov; e.exp_src = 2'(src);
        e.exp_first = f; e.exp_last = la; e.exp_upd = up;
        tbl.push_back(e);
    endtask

    initial begin
        int beats, bad;
        logic done;
        rst = 1'b1; in_valid = '0; in_len = '0; out_ready = 1'b0;
        force_en = 1'b0; force_grant = '0; force_any = 1'b0;
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = data_of(i);

        // Round robin, all valid, len=1: owners 0,1,2,3,0, three cycles each.
        for (int k = 0; k < 5; k++) begin
            int s, p;
            s = k % 4;
            p = (k == 0) ? 0 : (k - 1) % 4;
            add(k == 0, 4'b1111, mk_len(1,1,1,1), 1, 4'b1111, 4'b0000, 0, p, 0, 0, 0);
            add(0, 4'b1111, mk_len(1,1,1,1), 1, oh(s), oh(s), 1, s, 1, 0, 0);
            add(0, 4'b1111, mk_len(1,1,1,1), 1, oh(s), oh(s), 1, s, 0, 1, 1);
        end
        // Only req 2, len=0: single beat with first=last=1.
        add(1, 4'b0100, mk_len(0,0,0,0), 1, 4'b0100, 4'b0000, 0, 0, 0, 0, 0);
        add(0, 4'b0100, mk_len(0,0,0,0), 1, 4'b0100, 4'b0100, 1, 2, 1, 1, 1);
        add(0, 4'b0000, mk_len(0,0,0,0), 1, 4'b0000, 4'b0000, 0, 2, 0, 0, 0);
        add(0, 4'b0000, mk_len(0,0,0,0), 1, 4'b0000, 4'b0000, 0, 2, 0, 0, 0);
        // Req 1 len=3 with out_ready toggling; len change after lock ignored.
        add(1, 4'b0010, mk_len(0,3,0,0), 1, 4'b0010, 4'b0000, 0, 0, 0, 0, 0);
        add(0, 4'b1011, mk_len(0,3,0,0), 1, 4'b0010, 4'b0010, 1, 1, 1, 0, 0);
        add(0, 4'b1011, mk_len(0,0,0,0), 0, 4'b0010, 4'b0000, 1, 1, 0, 0, 0);
        add(0, 4'b1011, mk_len(0,0,0,0), 1, 4'b0010, 4'b0010, 1, 1, 0, 0, 0);
        add(0, 4'b1011, mk_len(0,0,0,0), 0, 4'b0010, 4'b0000, 1, 1, 0, 0, 0);
        add(0, 4'b1011, mk_len(0,0,0,0), 1, 4'b0010, 4'b0010, 1, 1, 0, 0, 0);
        add(0, 4'b1011, mk_len(0,0,0,0), 0, 4'b0010, 4'b0000, 1, 1, 0, 1, 0);
        add(0, 4'b1011, mk_len(0,0,0,0), 1, 4'b0010, 4'b0010, 1, 1, 0, 1, 1);
        add(0, 4'b1011, mk_len(0,0,0,0), 1, 4'b1011, 4'b0000, 0, 1, 0, 0, 0);
        add(0, 4'b1011, mk_len(0,0,0,0), 1, 4'b1000, 4'b1000, 1, 3, 1, 1, 1);
        // Req 0 len=2 drops valid for 5 cycles while req 3 waits.
        add(1, 4'b1001, mk_len(2,0,0,0), 1, 4'b1001, 4'b0000, 0, 0, 0, 0, 0);
        add(0, 4'b1001, mk_len(2,0,0,0), 1, 4'b0001, 4'b0001, 1, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++)
            add(0, 4'b1000, mk_len(2,0,0,0), 1, 4'b0001, 4'b0001, 0, 0, 0, 0, 0);
        add(0, 4'b1001, mk_len(2,0,0,0), 1, 4'b0001, 4'b0001, 1, 0, 0, 0, 0);
        add(0, 4'b1001, mk_len(2,0,0,0), 1, 4'b0001, 4'b0001, 1, 0, 0, 1, 1);
        add(0, 4'b1000, mk_len(2,0,0,0), 1, 4'b1000, 4'b0000, 0, 0, 0, 0, 0);
        add(0, 4'b1000, mk_len(2,0,0,0), 1, 4'b1000, 4'b1000, 1, 3, 1, 1, 1);

        foreach (tbl[r]) begin
            if (tbl[r].rst_before) do_reset();
            cur_row   = r;
            in_valid  = tbl[r].valid;
            in_len    = tbl[r].len;
            out_ready = tbl[r].rdy;
            #1;
            chk("req", arb_request, tbl[r].exp_req);
            chk("in_ready", in_ready, tbl[r].exp_ready);
            chk("out_valid", out_valid, tbl[r].exp_valid);
            chk("out_src", out_src, tbl[r].exp_src);
            chk("out_data", out_data, data_of(int'(tbl[r].exp_src)));
            chk("out_first", out_first, tbl[r].exp_first);
            chk("out_last", out_last, tbl[r].exp_last);
            chk("update_pri", arb_update_pri, tbl[r].exp_upd);
            chk("err_grant", err_grant, 0);
            @(negedge clk);
        end
        cur_row = -1;

        // ---- len=255 on req 3: 256 beats, last only on the final one ----
        do_reset();
        in_valid = 4'b1000; in_len = mk_len(0,0,0,255); out_ready = 1'b1;
        @(negedge clk);
        beats = 0; bad = 0; done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            #1;
            if (out_valid && out_ready) begin
                beats++;
                if (out_src != 2'd3) bad++;
                if (out_first != (beats == 1)) bad++;
                if (out_last != (beats == 256)) bad++;
                if (arb_update_pri != (beats == 256)) bad++;
                if (out_last) done = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = '0;
        chk("long_done", done, 1);
        chk("long_beats", beats, 256);
        chk("long_bad", bad, 0);
        #1;
        chk("long_idle_state", state_dbg, 0);
        chk("long_idle_valid", out_valid, 0);
        @(negedge clk);

        // ---- async reset during beat 2 of a len=3 burst on req 2 ----
        do_reset();
        in_valid = 4'b0100; in_len = mk_len(0,0,3,0); out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rb_beat1_first", out_first, 1);
        chk("rb_beat1_src", out_src, 2);
        @(negedge clk);
        #1;
        chk("rb_beat2_valid", out_valid, 1);
        chk("rb_beat2_first", out_first, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rb_async_valid", out_valid, 0);
        chk("rb_async_src", out_src, 0);
        chk("rb_async_ready", in_ready, 0);
        chk("rb_async_state", state_dbg, 0);
        chk("rb_async_req", arb_request, 4'b0100);
        chk("rb_async_upd", arb_update_pri, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rb_idle_upd", arb_update_pri, 0);
        chk("rb_idle_valid", out_valid, 0);
        @(negedge clk);
        #1;
        chk("rb_relock_first", out_first, 1);
        chk("rb_relock_last", out_last, 0);
        in_valid = '0;

        // ---- grant protocol errors ----
        do_reset();
        in_valid = 4'b0110; in_len = mk_len(0,0,0,0);
        force_en = 1'b1; force_grant = 4'b0110; force_any = 1'b1;
        #1;
        chk("err_before", err_grant, 0);
        @(negedge clk);
        force_en = 1'b0; in_valid = '0;
        #1;
        chk("err_multi", err_grant, 1);
        chk("err_multi_src", out_src, 1);
        chk("err_multi_state", state_dbg, 1);
        do_reset();
        in_valid = 4'b0001; in_len = mk_len(1,0,0,0);
        @(negedge clk);
        force_en = 1'b1; force_grant = 4'b0100; force_any = 1'b1;
        #1;
        chk("err_lock_before", err_grant, 0);
        chk("err_lock_fwd", out_valid, 1);
        chk("err_lock_src", out_src, 0);
        @(negedge clk);
        force_en = 1'b0;
        #1;
        chk("err_lock_set", err_grant, 1);
        chk("err_lock_last", out_last, 1);
        chk("err_lock_upd", arb_update_pri, 1);
        @(negedge clk);
        in_valid = '0;
        #1;
        chk("err_sticky", err_grant, 1);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if something above stalls.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
